// File: rtl/smul_acc.sv
// rtl/smul_acc.sv - saturating product accumulator downstream of smul_16x16
//
// Sums a programmed number of signed products into a wide accumulator and
// saturates the total to the product width. The result is held for the
// register bus to poll.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse: latch len, zero accumulator, begin run
//   clear      one-cycle pulse: abort run, clear result and flags (beats start)
//   len        number of products to accumulate, sampled on start
//   in_valid   product on in_data valid this cycle (no backpressure)
//   in_data    signed product from the multiplier
//   busy       high while accumulating or saturating
//   out_valid  result valid; held until next start or clear
//   result     signed saturated sum
//   ovf        sticky: saturation occurred in this run
//   drop       sticky: a product arrived while not accumulating
//   count      products accepted so far in the current run
module smul_acc #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             busy,
  output logic             out_valid,
  output logic [IN_W-1:0]  result,
  output logic             ovf,
  output logic             drop,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_SAT,
    S_DONE
  } state_t;

  // Largest and smallest values representable in IN_W bits, expressed at
  // accumulator width so the saturation compare is a plain signed compare.
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {{(ACC_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {{(ACC_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0]  RES_MAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0]  RES_MIN = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [CNT_W-1:0]        len_r;
  logic signed [ACC_W-1:0] acc;

  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0]        count_inc;
  logic                    last_prod;
  logic                    sat_hi;
  logic                    sat_lo;

  assign in_ext    = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign acc_sum   = acc + in_ext;
  assign count_inc = count + CNT_ONE;
  // len_r is never zero in ACC: a zero length goes straight to SAT.
  assign last_prod = (count_inc == len_r);
  assign sat_hi    = (acc > ACC_MAX);
  assign sat_lo    = (acc < ACC_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_r     <= '0;
      acc       <= '0;
      count     <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      drop      <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= S_IDLE;
      acc       <= '0;
      count     <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      drop      <= 1'b0;
      busy      <= 1'b0;
    end else if (start) begin
      // Restart is legal from any state; a partial run is simply discarded.
      // Accumulation begins next cycle, so a product on the start cycle is
      // dropped and re-arms the sticky flag that start otherwise clears.
      len_r     <= len;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      drop      <= in_valid;
      busy      <= 1'b1;
      state     <= (len == '0) ? S_SAT : S_ACC;
    end else begin
      case (state)
        S_ACC: begin
          if (in_valid) begin
            acc   <= acc_sum;
            count <= count_inc;
            if (last_prod) begin
              state <= S_SAT;
            end
          end
        end
        S_SAT: begin
          if (sat_hi) begin
            result <= RES_MAX;
            ovf    <= 1'b1;
          end else if (sat_lo) begin
            result <= RES_MIN;
            ovf    <= 1'b1;
          end else begin
            result <= acc[IN_W-1:0];
          end
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_DONE;
          if (in_valid) begin
            drop <= 1'b1;
          end
        end
        S_IDLE, S_DONE: begin
          if (in_valid) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/smul_acc.md
Name: smul_acc

Overview:
Accumulator stage directly downstream of smul_16x16. It consumes the signed 32-bit product stream, sums a programmed number of products in a 40-bit accumulator, and saturates the sum to 32 bits. The result is held for the SPI register bus (cmdspi read mux) to poll. Together with the multiplier it forms the dot-product / FIR-tap datapath, driven by microcontroller register writes.

Parameters:
IN_W, 32, product width (signed), matches smul_16x16 outp
ACC_W, 40, internal accumulator width (signed); must be > IN_W
CNT_W, 8, width of product-count register; max run length 2^CNT_W-1

Ports:
clk  input  1  system clock (32MHz PLL domain)
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: latch len, zero accumulator, begin run
clear  input  1  one-cycle pulse: abort run, return to IDLE, clear result/flags
len  input  CNT_W  number of products to accumulate, sampled on start
in_valid  input  1  product on in_data valid this cycle (no backpressure)
in_data  input  IN_W  signed product from multiplier
busy  output  1  high in ACC and SAT states
out_valid  output  1  result valid; held until next start or clear
result  output  IN_W  signed saturated sum
ovf  output  1  sticky: saturation occurred in this run
drop  output  1  sticky: in_valid seen while not in ACC
count  output  CNT_W  products accepted so far in current run

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, count=0, result=0, out_valid=0, ovf=0, drop=0, busy=0. Effect is immediate, including mid-run; the run is lost.
- States: IDLE, ACC, SAT, DONE. All transitions are on posedge clk.
- IDLE/DONE, start=1: latch len to len_r, acc<=0, count<=0, out_valid<=0, ovf<=0, drop<=0. Next state is ACC, or SAT if len=0.
- ACC: each cycle with in_valid=1: acc<=acc+sign_ext(in_data) and count<=count+1. When the accepted product makes count+1==len_r, next state is SAT.
- ACC, in_valid=0: hold; no timeout.
- SAT: if acc>2^(IN_W-1)-1, result<=0x7FFFFFFF and ovf<=1. If acc<-2^(IN_W-1), result<=0x80000000 and ovf<=1. Otherwise result<=acc[IN_W-1:0]. Same edge: out_valid<=1, next state DONE.
- Latency: last product sampled at edge k. SAT occupies cycle k..k+1. result/out_valid are visible after edge k+1.
- DONE: result, out_valid, ovf held until start or clear.
- ACC width: 40 bits covers 255 full-scale products without internal wrap. Internal accumulator wrap is not required to be detected.
- start while in ACC or SAT: restart. Same actions as start from IDLE; the previous partial run is discarded and out_valid stays 0.
- clear: has priority over start in the same cycle. state<=IDLE, acc<=0, count<=0, result<=0, out_valid<=0, ovf<=0, drop<=0.
- in_valid outside ACC (including the start cycle itself and SAT): the product is ignored and drop<=1 (sticky until start/clear/reset).
- start and in_valid in the same cycle: the product is dropped (drop=1), because accumulation begins the following cycle.
- busy = (state==ACC) or (state==SAT). It is registered along with state, with no combinational path from inputs to outputs.

Test Plan:
- Reset, start with len=3, products 100, -50, 7 on consecutive cycles -> out_valid=1 two edges after last product, result=57, ovf=0, count=3.
- len=2, products 0x7FFFFFFF, 0x7FFFFFFF -> result=0x7FFFFFFF, ovf=1. Then len=2, products 0x80000000 twice -> result=0x80000000, ovf=1.
- len=0 start -> SAT next cycle, out_valid=1 one edge later, result=0, busy high exactly one cycle.
- len=4, products 1, 2 with gaps of 3 idle cycles, then start again with len=1 and product 9 -> result=9 (first run discarded), out_valid only after second run.
- in_valid with product 5 in IDLE, then on the start cycle, then clear and start together -> drop=1 until clear, clear wins: state IDLE, result=0, out_valid=0.
- Mid-run (count=2 of 5) assert rst_n=0 asynchronously between edges -> all outputs zero immediately. After release, new run len=1 product -3 -> result=0xFFFFFFFD.
